// File: rtl/rom_arbiter_2port.sv
// Two-requester arbiter in front of a single-port, registered-address ROM.
// Grants one read per cycle and steers the returned word to the port that issued it.
module rom_arbiter_2port #(
  parameter int AWIDTH       = 11,
  parameter int DWIDTH       = 32,
  parameter int FIX_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              p0_req,
  input  logic [AWIDTH-1:0] p0_addr,
  output logic              p0_ack,
  output logic              p0_valid,
  output logic [DWIDTH-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic [AWIDTH-1:0] p1_addr,
  output logic              p1_ack,
  output logic              p1_valid,
  output logic [DWIDTH-1:0] p1_rdata,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_dout
);

  logic              gnt0;
  logic              gnt1;
  logic              last_grant_q, last_grant_d;
  logic [AWIDTH-1:0] last_addr_q, last_addr_d;
  logic              inflight_q, inflight_d;
  logic              owner_q, owner_d;
  logic              p0_valid_q, p0_valid_d;
  logic              p1_valid_q, p1_valid_d;
  logic [DWIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DWIDTH-1:0] p1_rdata_q, p1_rdata_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (p0_req && p1_req) begin
      // last_grant_q == 1 means port 1 was served last, so port 0 is next
      if (FIX_PRIORITY != 0 || last_grant_q) gnt0 = 1'b1;
      else                                  gnt1 = 1'b1;
    end else begin
      gnt0 = p0_req;
      gnt1 = p1_req;
    end
  end

  assign p0_ack = gnt0;
  assign p1_ack = gnt1;

  always_comb begin
    rom_addr = last_addr_q;
    if (gnt0)      rom_addr = p0_addr;
    else if (gnt1) rom_addr = p1_addr;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    inflight_d   = gnt0 | gnt1;
    last_addr_d  = rom_addr;
    if (gnt0 | gnt1) begin
      last_grant_d = gnt1;
      owner_d      = gnt1;
    end
    // rom_dout belongs to the read launched one edge ago
    p0_valid_d = inflight_q && !owner_q;
    p1_valid_d = inflight_q &&  owner_q;
    p0_rdata_d = p0_valid_d ? rom_dout : p0_rdata_q;
    p1_rdata_d = p1_valid_d ? rom_dout : p1_rdata_q;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      last_grant_q <= 1'b1;
      last_addr_q  <= '0;
      inflight_q   <= 1'b0;
      owner_q      <= 1'b0;
      p0_valid_q   <= 1'b0;
      p1_valid_q   <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      last_addr_q  <= last_addr_d;
      inflight_q   <= inflight_d;
      owner_q      <= owner_d;
      p0_valid_q   <= p0_valid_d;
      p1_valid_q   <= p1_valid_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign p0_valid = p0_valid_q;
  assign p1_valid = p1_valid_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

endmodule
